// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I-subset core: sequences fetch, decode,
// execute, memory and writeback, and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [1:0]  ext_sel,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic        trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_LUI, CL_JAL
  } class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int            CW       = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state_r;
  class_t        cls_r;
  logic [CW-1:0] cnt_r;

  class_t        dec_class;
  logic [1:0]    dec_ext;
  logic          dec_legal;
  logic          timed_out;

  // Only opcode and funct3 steer control; the rest belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  assign state     = state_r;
  assign timed_out = !mem_ready && (cnt_r == CNT_LAST);

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    dec_legal = 1'b1;
    dec_class = CL_R;
    dec_ext   = 2'b00;
    case (instr[6:0])
      OP_R:      dec_class = CL_R;
      OP_IALU:   dec_class = CL_IALU;
      OP_LOAD:   dec_class = CL_LOAD;
      OP_STORE:  begin dec_class = CL_STORE; dec_ext = 2'b01; end
      OP_BRANCH: begin
        dec_class = CL_BRANCH;
        dec_ext   = 2'b10;
        dec_legal = (instr[14:13] == 2'b00);  // BEQ/BNE only
      end
      OP_LUI:    begin dec_class = CL_LUI; dec_ext = 2'b11; end
      OP_JAL:    begin dec_class = CL_JAL; dec_ext = 2'b11; end
      default:   dec_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FETCH;
      cls_r      <= CL_R;
      cnt_r      <= '0;
      ext_sel    <= 2'b00;
      trap       <= 1'b0;
      trap_cause <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            if (state_r == S_FETCH) begin
              state_r <= S_DECODE;
            end else if (cls_r == CL_STORE) begin
              state_r <= S_FETCH;
              cnt_r   <= '0;
            end else begin
              state_r <= S_WB;
            end
          end else if (timed_out) begin
            state_r    <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        S_DECODE: begin
          if (!dec_legal) begin
            state_r    <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 1'b0;
          end else begin
            state_r <= S_EXEC;
            cls_r   <= dec_class;
            ext_sel <= dec_ext;
          end
        end
        S_EXEC: begin
          case (cls_r)
            CL_LOAD, CL_STORE: begin state_r <= S_MEM;   cnt_r <= '0; end
            CL_BRANCH:         begin state_r <= S_FETCH; cnt_r <= '0; end
            default:           state_r <= S_WB;
          endcase
        end
        S_WB: begin
          state_r <= S_FETCH;
          cnt_r   <= '0;
        end
        S_TRAP: state_r <= S_TRAP;
        default: begin  // unreachable codes 5 and 6
          state_r <= S_FETCH;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Strobes and mux selects follow state directly; reset silences all of them.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    alu_src  = 1'b0;
    alu_op   = 2'b00;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 2'b00;
    if (!rst) begin
      case (state_r)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = mem_ready;
          pc_we    = mem_ready;
        end
        S_EXEC: begin
          case (cls_r)
            CL_R:              alu_op = 2'b10;
            CL_IALU:           begin alu_src = 1'b1; alu_op = 2'b10; end
            CL_LOAD, CL_STORE: alu_src = 1'b1;
            CL_BRANCH: begin
              alu_op = 2'b01;
              pc_we  = alu_zero ^ instr[12];
              pc_src = alu_zero ^ instr[12];
            end
            CL_JAL:            begin pc_we = 1'b1; pc_src = 1'b1; end
            default:           ;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_r == CL_STORE);
        end
        S_WB: begin
          reg_we = 1'b1;
          case (cls_r)
            CL_LOAD: wb_sel = 2'b01;
            CL_JAL:  wb_sel = 2'b10;
            CL_LUI:  wb_sel = 2'b11;
            default: wb_sel = 2'b00;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each applied cycle pushes the expected
// output vector; scenario tasks pop and compare against the sampled outputs.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_we, pc_we, pc_src;
    logic [1:0] ext_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       dmem_req, dmem_we, reg_we;
    logic [1:0] wb_sel;
    logic       trap, trap_cause;
  } outs_t;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h00012083;
  localparam logic [31:0] SW   = 32'h00112223;
  localparam logic [31:0] BEQ  = 32'h00208063;
  localparam logic [31:0] BNE  = 32'h00209063;
  localparam logic [31:0] BLT  = 32'h0020C063;
  localparam logic [31:0] JAL  = 32'h000000EF;
  localparam logic [31:0] LUI  = 32'h000010B7;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] BAD  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        imem_req, ir_we, pc_we, pc_src, alu_src;
  logic        dmem_req, dmem_we, reg_we, trap, trap_cause;
  logic [1:0]  ext_sel, alu_op, wb_sel;
  logic [2:0]  state;

  int    vectors = 0;
  int    errors  = 0;
  outs_t exp_q[$];
  outs_t obs_q[$];

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .ext_sel(ext_sel), .alu_src(alu_src), .alu_op(alu_op),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .state(state), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  function automatic outs_t base(input logic [2:0] st, input logic [1:0] es);
    outs_t o = '0;
    o.st = st;
    o.ext_sel = es;
    return o;
  endfunction

  function automatic outs_t x_fetch(input logic [1:0] es, input logic rdy);
    outs_t o = base(3'd0, es);
    o.imem_req = 1'b1;
    o.ir_we = rdy;
    o.pc_we = rdy;
    return o;
  endfunction

  function automatic outs_t x_dec(input logic [1:0] es);
    return base(3'd1, es);
  endfunction

  function automatic outs_t x_exec(input logic [1:0] es, input logic asrc,
                                   input logic [1:0] aop, input logic pcw);
    outs_t o = base(3'd2, es);
    o.alu_src = asrc;
    o.alu_op = aop;
    o.pc_we = pcw;
    o.pc_src = pcw;
    return o;
  endfunction

  function automatic outs_t x_mem(input logic [1:0] es, input logic we);
    outs_t o = base(3'd3, es);
    o.dmem_req = 1'b1;
    o.dmem_we = we;
    return o;
  endfunction

  function automatic outs_t x_wb(input logic [1:0] es, input logic [1:0] ws);
    outs_t o = base(3'd4, es);
    o.reg_we = 1'b1;
    o.wb_sel = ws;
    return o;
  endfunction

  function automatic outs_t x_trap(input logic [1:0] es, input logic cause);
    outs_t o = base(3'd7, es);
    o.trap = 1'b1;
    o.trap_cause = cause;
    return o;
  endfunction

  function automatic outs_t sample();
    return '{state, imem_req, ir_we, pc_we, pc_src, ext_sel, alu_src, alu_op,
             dmem_req, dmem_we, reg_we, wb_sel, trap, trap_cause};
  endfunction

  // One clock cycle: drive inputs on the falling edge, record expectation,
  // capture the outputs mid-cycle.
  task automatic apply(input bit chk, input logic r, input logic [31:0] ins,
                       input logic rdy, input logic z, input outs_t e);
    @(negedge clk);
    rst = r;
    instr = ins;
    mem_ready = rdy;
    alu_zero = z;
    #1;
    if (chk) begin
      exp_q.push_back(e);
      obs_q.push_back(sample());
    end
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b1, ADDI, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    outs_t e, o;
    int n = 0;
    do_reset();
    apply(1'b1, 1'b1, ADDI, 1'b1, 1'b1, base(3'd0, 2'b00));
    apply(1'b1, 1'b0, ADDI, 1'b0, 1'b0, x_fetch(2'b00, 1'b0));
    apply(1'b1, 1'b0, ADDI, 1'b0, 1'b0, x_fetch(2'b00, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset cyc%0d: got %h, expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_addi();
    outs_t e, o;
    int n = 0;
    do_reset();
    apply(1'b1, 1'b0, ADDI, 1'b1, 1'b0, x_fetch(2'b00, 1'b1));
    apply(1'b1, 1'b0, ADDI, 1'b1, 1'b0, x_dec(2'b00));
    apply(1'b1, 1'b0, ADDI, 1'b1, 1'b0, x_exec(2'b00, 1'b1, 2'b10, 1'b0));
    apply(1'b1, 1'b0, ADDI, 1'b1, 1'b0, x_wb(2'b00, 2'b00));
    apply(1'b1, 1'b0, ADDI, 1'b1, 1'b0, x_fetch(2'b00, 1'b1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL addi cyc%0d: got %h, expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_load_wait();
    outs_t e, o;
    int n = 0;
    do_reset();
    apply(1'b1, 1'b0, LW, 1'b1, 1'b0, x_fetch(2'b00, 1'b1));
    apply(1'b1, 1'b0, LW, 1'b1, 1'b0, x_dec(2'b00));
    apply(1'b1, 1'b0, LW, 1'b1, 1'b0, x_exec(2'b00, 1'b1, 2'b00, 1'b0));
    for (int i = 0; i < 3; i++)
      apply(1'b1, 1'b0, LW, 1'b0, 1'b0, x_mem(2'b00, 1'b0));
    apply(1'b1, 1'b0, LW, 1'b1, 1'b0, x_mem(2'b00, 1'b0));
    apply(1'b1, 1'b0, LW, 1'b1, 1'b0, x_wb(2'b00, 2'b01));
    apply(1'b1, 1'b0, LW, 1'b0, 1'b0, x_fetch(2'b00, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_wait cyc%0d: got %h, expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_store_reset();
    outs_t e, o;
    int n = 0;
    do_reset();
    apply(1'b1, 1'b0, SW, 1'b1, 1'b0, x_fetch(2'b00, 1'b1));
    apply(1'b1, 1'b0, SW, 1'b0, 1'b0, x_dec(2'b00));
    apply(1'b1, 1'b0, SW, 1'b0, 1'b0, x_exec(2'b01, 1'b1, 2'b00, 1'b0));
    apply(1'b1, 1'b0, SW, 1'b1, 1'b0, x_mem(2'b01, 1'b1));
    apply(1'b1, 1'b0, SW, 1'b1, 1'b0, x_fetch(2'b01, 1'b1));
    apply(1'b1, 1'b0, SW, 1'b0, 1'b0, x_dec(2'b01));
    apply(1'b1, 1'b0, SW, 1'b0, 1'b0, x_exec(2'b01, 1'b1, 2'b00, 1'b0));
    apply(1'b1, 1'b0, SW, 1'b0, 1'b0, x_mem(2'b01, 1'b1));
    apply(1'b1, 1'b1, SW, 1'b0, 1'b0, base(3'd3, 2'b01));
    apply(1'b1, 1'b0, SW, 1'b0, 1'b0, x_fetch(2'b00, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL store_reset cyc%0d: got %h, expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_branch();
    outs_t e, o;
    int n = 0;
    logic [31:0] b_ins [4] = '{BEQ, BEQ, BNE, BNE};
    logic        b_z   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        b_tk  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  es = 2'b00;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, b_ins[i], 1'b1, ~b_z[i], x_fetch(es, 1'b1));
      apply(1'b1, 1'b0, b_ins[i], 1'b1, ~b_z[i], x_dec(es));
      es = 2'b10;
      apply(1'b1, 1'b0, b_ins[i], 1'b1, b_z[i], x_exec(es, 1'b0, 2'b01, b_tk[i]));
    end
    apply(1'b1, 1'b0, BLT, 1'b1, 1'b1, x_fetch(2'b10, 1'b1));
    apply(1'b1, 1'b0, BLT, 1'b1, 1'b1, x_dec(2'b10));
    apply(1'b1, 1'b0, BLT, 1'b1, 1'b1, x_trap(2'b10, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL branch cyc%0d: got %h, expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    outs_t e, o;
    int n = 0;
    do_reset();
    apply(1'b1, 1'b0, JAL, 1'b1, 1'b0, x_fetch(2'b00, 1'b1));
    apply(1'b1, 1'b0, JAL, 1'b1, 1'b0, x_dec(2'b00));
    apply(1'b1, 1'b0, JAL, 1'b1, 1'b0, x_exec(2'b11, 1'b0, 2'b00, 1'b1));
    apply(1'b1, 1'b0, JAL, 1'b1, 1'b0, x_wb(2'b11, 2'b10));
    apply(1'b1, 1'b0, LUI, 1'b1, 1'b0, x_fetch(2'b11, 1'b1));
    apply(1'b1, 1'b0, LUI, 1'b1, 1'b0, x_dec(2'b11));
    apply(1'b1, 1'b0, LUI, 1'b1, 1'b0, x_exec(2'b11, 1'b0, 2'b00, 1'b0));
    apply(1'b1, 1'b0, LUI, 1'b1, 1'b0, x_wb(2'b11, 2'b11));
    apply(1'b1, 1'b0, ADD, 1'b1, 1'b1, x_fetch(2'b11, 1'b1));
    apply(1'b1, 1'b0, ADD, 1'b1, 1'b1, x_dec(2'b11));
    apply(1'b1, 1'b0, ADD, 1'b1, 1'b1, x_exec(2'b00, 1'b0, 2'b10, 1'b0));
    apply(1'b1, 1'b0, ADD, 1'b1, 1'b1, x_wb(2'b00, 2'b00));
    apply(1'b1, 1'b0, ADD, 1'b0, 1'b0, x_fetch(2'b00, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %h, expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_illegal();
    outs_t e, o;
    int n = 0;
    do_reset();
    apply(1'b1, 1'b0, BAD, 1'b1, 1'b0, x_fetch(2'b00, 1'b1));
    apply(1'b1, 1'b0, BAD, 1'b1, 1'b0, x_dec(2'b00));
    for (int i = 0; i < 3; i++)
      apply(1'b1, 1'b0, ADDI, 1'b1, 1'b1, x_trap(2'b00, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL illegal cyc%0d: got %h, expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_timeout();
    outs_t e, o;
    int n = 0;
    do_reset();
    for (int i = 0; i < 16; i++)
      apply(1'b1, 1'b0, ADDI, 1'b0, 1'b0, x_fetch(2'b00, 1'b0));
    for (int i = 0; i < 2; i++)
      apply(1'b1, 1'b0, ADDI, 1'b1, 1'b0, x_trap(2'b00, 1'b1));
    // Ready on the last allowed cycle completes, then a load times out in MEM.
    do_reset();
    for (int i = 0; i < 15; i++)
      apply(1'b1, 1'b0, LW, 1'b0, 1'b0, x_fetch(2'b00, 1'b0));
    apply(1'b1, 1'b0, LW, 1'b1, 1'b0, x_fetch(2'b00, 1'b1));
    apply(1'b1, 1'b0, LW, 1'b0, 1'b0, x_dec(2'b00));
    apply(1'b1, 1'b0, LW, 1'b0, 1'b0, x_exec(2'b00, 1'b1, 2'b00, 1'b0));
    for (int i = 0; i < 16; i++)
      apply(1'b1, 1'b0, LW, 1'b0, 1'b0, x_mem(2'b00, 1'b0));
    apply(1'b1, 1'b0, LW, 1'b1, 1'b0, x_trap(2'b00, 1'b1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++; n++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout cyc%0d: got %h, expected %h", n, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_store_reset();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
